crc_enc_arbiter: RTL

- Shares one CRC-24 encoder instance (K=40 data bits, N=64 codeword bits) between R requesters.
- Accepts requests under a valid/ready handshake and arbitrates them round-robin.
- Sequences the encoder's start/done protocol and returns each codeword with the winning requester's ID on a valid/ready output channel.
- Sits between the frame-builder clients and the encoder.

---
 rtl/crc_enc_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 47 ++++
 rtl/crc_enc_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/crc_enc_pkg.sv
// Shared definitions for the CRC-24 encoder arbiter: codeword geometry,
// encoder latency default and the arbiter FSM state type.
package crc_enc_pkg;

    localparam int K_DEF       = 40;
    localparam int N_DEF       = 64;
    localparam int CRC_W       = 24;
    localparam int ENC_LAT_DEF = 2;

    // Codeword layout: {data[K-1:0], crc[CRC_W-1:0]}
    localparam int CW_CRC_LSB  = 0;
    localparam int CW_DATA_LSB = CRC_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_OUT
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request
// searching upward from last_grant+1 with wrap-around.
module rr_arbiter #(
    parameter int R    = 4,
    parameter int IDXW = (R > 1) ? $clog2(R) : 1
) (
    input  logic [R-1:0]    req,
    input  logic [IDXW-1:0] last_grant,
    output logic [R-1:0]    grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            grant_valid
);

    logic [2*R-1:0] req_dbl;
    logic [R-1:0]   req_rot;
    int             base;
    int             pos;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = 0;
        base        = int'(last_grant) + 1;
        if (base >= R) begin
            base = 0;
        end
        // Rotating the doubled vector puts the highest-priority request at bit 0.
        req_dbl = {req, req} >> base;
        req_rot = req_dbl[R-1:0];
        for (int i = 0; i < R; i++) begin
            if (!grant_valid && req_rot[i]) begin
                grant_valid = 1'b1;
                pos         = i + base;
                if (pos >= R) begin
                    pos = pos - R;
                end
            end
        end
        if (grant_valid) begin
            grant     = R'(1) << pos;
            grant_idx = IDXW'(pos);
        end
    end

endmodule

// File: rtl/crc_enc_arbiter.sv
// Round-robin front end sharing one CRC-24 encoder between R requesters.
// Define CRC_ARB_STATS_EN to add the stat_jobs / stat_timeouts counters.
module crc_enc_arbiter
    import crc_enc_pkg::*;
#(
    parameter int R           = 4,
    parameter int K           = K_DEF,
    parameter int N           = N_DEF,
    parameter int IDW         = 2,
    parameter int ENC_LAT     = ENC_LAT_DEF,
    parameter int ENC_TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [R-1:0]   req_valid,
    input  logic [R*K-1:0] req_data,
    output logic [R-1:0]   req_ready,
    output logic           enc_start,
    output logic [K-1:0]   enc_data,
    input  logic           enc_done,
    input  logic [N-1:0]   enc_codeword,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic [IDW-1:0] out_id,
    output logic           busy,
`ifdef CRC_ARB_STATS_EN
    output logic [15:0]    stat_jobs,
    output logic [15:0]    stat_timeouts,
`endif
    output logic           timeout_err
);

    localparam int AW    = (R > 1) ? $clog2(R) : 1;
    localparam int CNT_W = $clog2(ENC_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(ENC_LAT - 1);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(ENC_TIMEOUT - 1);

    arb_state_e     state_q, state_d;
    logic [AW-1:0]  last_grant_q, last_grant_d;
    logic [AW-1:0]  id_q, id_d;
    logic [K-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic [IDW-1:0] out_id_q, out_id_d;

    logic [R-1:0]   grant;
    logic [AW-1:0]  grant_idx;
    logic           grant_valid;
    logic           done_qual;

    rr_arbiter #(
        .R    (R),
        .IDXW (AW)
    ) u_rr_arbiter (
        .req         (req_valid),
        .last_grant  (last_grant_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A done left high from the previous job is ignored until the encoder
    // has had ENC_LAT cycles to work on the current one.
    assign done_qual = enc_done && (cnt_q >= LAT_M1);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        hold_d       = hold_q;
        cnt_d        = cnt_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        req_ready    = '0;
        enc_start    = 1'b0;
        timeout_err  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    req_ready = grant;
                    id_d      = grant_idx;
                    for (int i = 0; i < R; i++) begin
                        if (grant[i]) begin
                            hold_d = req_data[i*K +: K];
                        end
                    end
                    state_d = ST_START;
                end
            end
            ST_START: begin
                enc_start = 1'b1;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (done_qual) begin
                    out_data_d = enc_codeword;
                    out_id_d   = IDW'(id_q);
                    state_d    = ST_OUT;
                end else if (cnt_q == TO_M1) begin
                    timeout_err  = 1'b1;
                    last_grant_d = id_q;
                    state_d      = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    last_grant_d = out_id_q[AW-1:0];
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= AW'(R - 1);
            id_q         <= '0;
            hold_q       <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_id_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            hold_q       <= hold_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
        end
    end

    assign enc_data  = hold_q;
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef CRC_ARB_STATS_EN
    logic [15:0] stat_jobs_q, stat_jobs_d;
    logic [15:0] stat_timeouts_q, stat_timeouts_d;

    always_comb begin
        stat_jobs_d     = stat_jobs_q;
        stat_timeouts_d = stat_timeouts_q;
        if (out_valid && out_ready) begin
            stat_jobs_d = stat_jobs_q + 16'd1;
        end
        if (timeout_err) begin
            stat_timeouts_d = stat_timeouts_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_jobs_q     <= '0;
            stat_timeouts_q <= '0;
        end else begin
            stat_jobs_q     <= stat_jobs_d;
            stat_timeouts_q <= stat_timeouts_d;
        end
    end

    assign stat_jobs     = stat_jobs_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule
